fetch_buffer: RTL

Parametrised, decoupled instruction-fetch stage; the successor to the fixed dual-issue fetch path. Each cycle it fetches `ISSUE_WIDTH` consecutive words from instruction memory into a circular instruction queue of `DEPTH` entries. Decode drains up to `ISSUE_WIDTH` instructions per cycle, oldest first. Adds a stall input, back-pressure when the queue is full, and flush-on-redirect for branches and jumps.

---
 rtl/fetch_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Decoupled instruction-fetch stage. Fetches ISSUE_WIDTH words per cycle into a circular queue
// and drains oldest first. Define FETCH_PC_TAG_EN to store and present a fetch PC per entry.
module fetch_buffer #(
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter int unsigned                ISSUE_WIDTH = 2,
  parameter int unsigned                DEPTH       = 8,
  parameter logic [DATA_WIDTH-1:0]      RESET_PC    = '0,
  localparam int unsigned               CW          = $clog2(ISSUE_WIDTH + 1),
  localparam int unsigned               OW          = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [DATA_WIDTH-1:0]         redirect_pc,
  output logic [DATA_WIDTH-1:0]         imem_addr,
  input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0] imem_rdata,
  input  logic [CW-1:0]                 deq_count,
  output logic [ISSUE_WIDTH-1:0]        out_valid,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_instr,
`ifdef FETCH_PC_TAG_EN
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_pc,
`endif
  output logic [OW-1:0]                 occupancy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [OW-1:0]         r_occ;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
`ifdef FETCH_PC_TAG_EN
  logic [DATA_WIDTH-1:0] r_pc_mem [DEPTH];
`endif

  logic [OW-1:0] w_deq_eff;
  logic [31:0]   w_space;
  logic          w_enq;

  always_comb begin
    w_deq_eff = OW'(deq_count);
    if (w_deq_eff > r_occ) w_deq_eff = r_occ;
    if (w_deq_eff > OW'(ISSUE_WIDTH)) w_deq_eff = OW'(ISSUE_WIDTH);
    // Space freed by this cycle's dequeue is usable by this cycle's enqueue.
    w_space = 32'(DEPTH) - 32'(r_occ) + 32'(w_deq_eff);
    w_enq   = !rst && !redirect_valid && !stall && (w_space >= 32'(ISSUE_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (redirect_valid) begin
      r_pc   <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PW'(ISSUE_WIDTH);
        r_pc   <= r_pc + DATA_WIDTH'(4 * ISSUE_WIDTH);
      end
      r_head <= r_head + PW'(w_deq_eff);
      r_occ  <= r_occ + (w_enq ? OW'(ISSUE_WIDTH) : OW'(0)) - w_deq_eff;
    end
  end

  // Entry storage needs no reset; stale entries are masked by occupancy.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        r_mem[r_tail + PW'(i)] <= imem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef FETCH_PC_TAG_EN
        r_pc_mem[r_tail + PW'(i)] <= r_pc + DATA_WIDTH'(4 * i);
`endif
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_instr = '0;
`ifdef FETCH_PC_TAG_EN
    out_pc    = '0;
`endif
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (OW'(i) < r_occ) begin
        out_valid[i] = 1'b1;
        out_instr[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_head + PW'(i)];
`ifdef FETCH_PC_TAG_EN
        out_pc[i*DATA_WIDTH +: DATA_WIDTH] = r_pc_mem[r_head + PW'(i)];
`endif
      end
    end
  end

  assign imem_addr = r_pc;
  assign occupancy = r_occ;

endmodule
